// File: rtl/pcileech_bar_impl_regwin.sv
// BAR backing store: writable register window at offset 0, read-only ID word, fill value elsewhere.
// Window is cleared after reset; reads go through a 1-stage pipeline into a response FIFO.
module pcileech_bar_impl_regwin #(
  parameter int          ADDR_BITS  = 12,
  parameter int          WIN_BYTES  = 64,
  parameter logic [31:0] FILL_VALUE = 32'h00000000,
  parameter logic [31:0] ID_OFFSET  = 32'h00000FFC,
  parameter logic [31:0] ID_VALUE   = 32'h00000000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wr_addr,
  input  logic [3:0]  i_wr_be,
  input  logic [31:0] i_wr_data,
  input  logic        i_wr_valid,
  input  logic [87:0] i_rd_req_ctx,
  input  logic [31:0] i_rd_req_addr,
  input  logic        i_rd_req_valid,
  output logic        o_rd_req_ready,
  output logic [87:0] o_rd_rsp_ctx,
  output logic [31:0] o_rd_rsp_data,
  output logic        o_rd_rsp_valid,
  input  logic        i_rd_rsp_ready,
  output logic        o_init_busy
);

  localparam int WIN_WORDS = WIN_BYTES / 4;
  localparam int WIN_IDX_W = (WIN_WORDS > 1) ? $clog2(WIN_WORDS) : 1;
  localparam int MEM_WORDS = 1 << WIN_IDX_W;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam logic [WIN_IDX_W-1:0] INIT_LAST = WIN_IDX_W'(WIN_WORDS - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t                r_state;
  logic [WIN_IDX_W-1:0]  r_init_idx;
  logic                  r_init_busy;
  logic [31:0]           r_mem [MEM_WORDS];

  logic                  r_s1_valid;
  logic [87:0]           r_s1_ctx;
  logic [31:0]           r_s1_data;

  logic [87:0]           r_fifo_ctx  [FIFO_DEPTH];
  logic [31:0]           r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic [ADDR_BITS-1:0]  w_wr_off;
  logic [ADDR_BITS-1:0]  w_rd_off;
  logic                  w_wr_in_win;
  logic                  w_rd_in_win;
  logic                  w_rd_is_id;
  logic [WIN_IDX_W-1:0]  w_wr_idx;
  logic [WIN_IDX_W-1:0]  w_rd_idx;
  logic                  w_wr_fire;
  logic                  w_rd_accept;
  logic [31:0]           w_wr_merged;
  logic [31:0]           w_rd_word;
  logic [CNT_W:0]        w_occupancy;
  logic                  w_push;
  logic                  w_pop;

  // Only the low ADDR_BITS of each address decode; the rest alias.
  assign w_wr_off    = i_wr_addr[ADDR_BITS-1:0];
  assign w_rd_off    = i_rd_req_addr[ADDR_BITS-1:0];
  assign w_wr_in_win = 33'(w_wr_off) < 33'(WIN_BYTES);
  assign w_rd_in_win = 33'(w_rd_off) < 33'(WIN_BYTES);
  assign w_rd_is_id  = (w_rd_off[ADDR_BITS-1:2] == ID_OFFSET[ADDR_BITS-1:2]);
  assign w_wr_idx    = w_wr_off[2 +: WIN_IDX_W];
  assign w_rd_idx    = w_rd_off[2 +: WIN_IDX_W];

  generate
    if (ADDR_BITS < 32) begin : g_alias
      logic w_unused_hi;
      assign w_unused_hi = ^{i_wr_addr[31:ADDR_BITS], i_rd_req_addr[31:ADDR_BITS]};
    end
  endgenerate

  assign w_wr_fire   = (r_state == ST_RUN) && i_wr_valid && w_wr_in_win;
  assign w_rd_accept = i_rd_req_valid && o_rd_req_ready;

  always_comb begin
    w_wr_merged = r_mem[w_wr_idx];
    for (int b = 0; b < 4; b++) begin
      if (i_wr_be[b]) begin
        w_wr_merged[8*b +: 8] = i_wr_data[8*b +: 8];
      end
    end
  end

  // A same-cycle write to the word being read is forwarded so the read sees post-write data.
  always_comb begin
    w_rd_word = FILL_VALUE;
    if (w_rd_in_win) begin
      if (w_wr_fire && (w_wr_idx == w_rd_idx)) begin
        w_rd_word = w_wr_merged;
      end else begin
        w_rd_word = r_mem[w_rd_idx];
      end
    end else if (w_rd_is_id) begin
      w_rd_word = ID_VALUE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_INIT;
      r_init_idx  <= '0;
      r_init_busy <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (r_init_idx == INIT_LAST) begin
            r_state     <= ST_RUN;
            r_init_busy <= 1'b0;
          end else begin
            r_init_idx <= r_init_idx + 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state     <= ST_INIT;
          r_init_idx  <= '0;
          r_init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign o_init_busy = r_init_busy;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (r_state == ST_INIT) begin
        r_mem[r_init_idx] <= 32'h00000000;
      end else if (w_wr_fire) begin
        r_mem[w_wr_idx] <= w_wr_merged;
      end
    end
  end

  // Reads in the pipeline stage count against FIFO space so an accepted read always has a slot.
  assign w_occupancy    = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
  assign o_rd_req_ready = (r_state == ST_RUN) && (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_ctx   <= '0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= w_rd_accept;
      if (w_rd_accept) begin
        r_s1_ctx  <= i_rd_req_ctx;
        r_s1_data <= w_rd_word;
      end
    end
  end

  assign w_push = r_s1_valid;
  assign w_pop  = o_rd_rsp_valid && i_rd_rsp_ready;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_ctx[r_wptr]  <= r_s1_ctx;
      r_fifo_data[r_wptr] <= r_s1_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs read as zero whenever nothing is queued, which also covers the reset values.
  assign o_rd_rsp_valid = (r_count != '0);
  assign o_rd_rsp_ctx   = o_rd_rsp_valid ? r_fifo_ctx[r_rptr]  : '0;
  assign o_rd_rsp_data  = o_rd_rsp_valid ? r_fifo_data[r_rptr] : '0;

endmodule
